pipe_stage_skid: RTL and testbench

//  Generic pipeline stage register replacing the fixed-field stage latches between pipeline stages.
//  - Carries one packed payload of DATA_W bits with a valid/ready handshake.
//  - A 2-entry skid buffer gives full throughput with a registered upstream ready.
//  - Synchronous flush (stg_x) turns the stage into a zero bubble.

---
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer and synchronous flush
// Optional performance counters are built only when STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int DATA_W = 107,
  parameter int CNT_W  = 16
) (
  input  logic              stg_clk,
  input  logic              reset,
  input  logic              stg_x,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Flush wins over any handshake; a concurrent out_fire still counts downstream.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (stg_x) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // in_ready is registered-state only so it never combinationally follows out_ready.
  always_comb begin
    out_valid = 1'b0;
    occupancy = 2'd0;
    in_ready  = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_EMPTY: begin
        occupancy = 2'd0;
        in_ready  = ~stg_x;
      end
      ST_BUSY: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
        in_ready  = ~stg_x;
        out_data  = main_q;
      end
      ST_FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
        out_data  = main_q;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

`ifdef STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (stg_x && state_q != ST_EMPTY && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
// Counter expectations follow STAGE_PERF_EN when it is defined for the build.
module tb_pipe_stage_skid;

  localparam int DATA_W = 107;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;
`ifdef STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              stg_clk = 1'b0;
  logic              reset;
  logic              stg_x;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .stg_clk  (stg_clk),
    .reset    (reset),
    .stg_x    (stg_x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 stg_clk = ~stg_clk;

  typedef struct {
    logic              x;
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              ov;
    logic [DATA_W-1:0] od;
    logic [1:0]        occ;
    logic              ir;
  } vec_t;

  vec_t tbl[22];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: a FIFO of at most two payloads plus counters
  logic [DATA_W-1:0] q[$];
  int stall_m = 0;
  int flush_m = 0;

  function automatic logic [DATA_W-1:0] pat(input int n);
    logic [31:0] nn;
    nn = n;
    return {nn[6:0] ^ 7'h55, 68'h0, nn};
  endfunction

  function automatic vec_t mk(input logic x, input logic iv, input logic [DATA_W-1:0] d,
                              input logic ordy, input logic ov, input logic [DATA_W-1:0] od,
                              input logic [1:0] occ, input logic ir);
    vec_t v;
    v.x = x; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic x, input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
    @(negedge stg_clk);
    stg_x     = x;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // advance the model across the coming rising edge using the inputs now applied
  task automatic mdl_edge();
    bit ir_m, of_m;
    ir_m = !stg_x && (q.size() < 2);
    of_m = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready && stall_m < CMAX) stall_m++;
    if (stg_x) begin
      if (q.size() > 0 && flush_m < CMAX) flush_m++;
      q.delete();
    end else begin
      if (of_m) void'(q.pop_front());
      if (in_valid && ir_m) q.push_back(in_data);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [DATA_W-1:0] od_m;
    od_m = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
    chk({tag, ".out_data"},  128'(out_data),  128'(od_m));
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(q.size()));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(!stg_x && q.size() < 2));
    chk({tag, ".stall_cnt"}, 128'(stall_cnt), PERF ? 128'(stall_m) : 128'(0));
    chk({tag, ".flush_cnt"}, 128'(flush_cnt), PERF ? 128'(flush_m) : 128'(0));
  endtask

  task automatic do_reset();
    @(negedge stg_clk);
    reset = 1'b1;
    stg_x = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    q.delete(); stall_m = 0; flush_m = 0;
    @(negedge stg_clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [127:0] r;
    reset = 1'b1;
    stg_x = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // streaming, backpressure, flush in FULL, flush+drain, flush while EMPTY
    tbl[0]  = mk(0, 1, pat(1),  1, 0, '0,      2'd0, 1);
    tbl[1]  = mk(0, 1, pat(2),  1, 1, pat(1),  2'd1, 1);
    tbl[2]  = mk(0, 1, pat(3),  1, 1, pat(2),  2'd1, 1);
    tbl[3]  = mk(0, 1, pat(4),  1, 1, pat(3),  2'd1, 1);
    tbl[4]  = mk(0, 0, '0,      1, 1, pat(4),  2'd1, 1);
    tbl[5]  = mk(0, 0, '0,      1, 0, '0,      2'd0, 1);
    tbl[6]  = mk(0, 1, pat(10), 0, 0, '0,      2'd0, 1);
    tbl[7]  = mk(0, 1, pat(11), 0, 1, pat(10), 2'd1, 1);
    tbl[8]  = mk(0, 1, pat(12), 0, 1, pat(10), 2'd2, 0);
    tbl[9]  = mk(0, 0, '0,      0, 1, pat(10), 2'd2, 0);
    tbl[10] = mk(0, 0, '0,      1, 1, pat(10), 2'd2, 0);
    tbl[11] = mk(0, 0, '0,      1, 1, pat(11), 2'd1, 1);
    tbl[12] = mk(0, 0, '0,      0, 0, '0,      2'd0, 1);
    tbl[13] = mk(0, 1, pat(20), 0, 0, '0,      2'd0, 1);
    tbl[14] = mk(0, 1, pat(21), 0, 1, pat(20), 2'd1, 1);
    tbl[15] = mk(1, 1, pat(22), 0, 1, pat(20), 2'd2, 0);
    tbl[16] = mk(0, 0, '0,      0, 0, '0,      2'd0, 1);
    tbl[17] = mk(0, 1, pat(30), 0, 0, '0,      2'd0, 1);
    tbl[18] = mk(1, 0, '0,      1, 1, pat(30), 2'd1, 0);
    tbl[19] = mk(0, 0, '0,      1, 0, '0,      2'd0, 1);
    tbl[20] = mk(1, 1, pat(40), 1, 0, '0,      2'd0, 0);
    tbl[21] = mk(0, 0, '0,      1, 0, '0,      2'd0, 1);

    // reset held, then released
    @(negedge stg_clk);
    @(negedge stg_clk);
    chk("rst.out_valid", 128'(out_valid), 128'(0));
    chk("rst.out_data",  128'(out_data),  128'(0));
    chk("rst.in_ready",  128'(in_ready),  128'(1));
    chk("rst.occupancy", 128'(occupancy), 128'(0));
    reset = 1'b0;
    @(negedge stg_clk);
    #1;
    chk("rel.out_valid", 128'(out_valid), 128'(0));
    chk("rel.out_data",  128'(out_data),  128'(0));
    chk("rel.in_ready",  128'(in_ready),  128'(1));
    chk("rel.occupancy", 128'(occupancy), 128'(0));

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].x, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      chk($sformatf("vec%0d.out_data", i),  128'(out_data),  128'(tbl[i].od));
      chk($sformatf("vec%0d.occupancy", i), 128'(occupancy), 128'(tbl[i].occ));
      chk($sformatf("vec%0d.in_ready", i),  128'(in_ready),  128'(tbl[i].ir));
      mdl_edge();
    end
    drive(0, 0, '0, 0);
    chk("vec.stall_cnt", 128'(stall_cnt), PERF ? 128'(5) : 128'(0));
    chk("vec.flush_cnt", 128'(flush_cnt), PERF ? 128'(2) : 128'(0));

    // stall counter saturation
    do_reset();
    drive(0, 1, pat(50), 0);
    mdl_edge();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, '0, 0);
      mdl_edge();
    end
    drive(0, 0, '0, 0);
    chk("sat.stall_cnt", 128'(stall_cnt), PERF ? 128'(CMAX) : 128'(0));
    chk("sat.out_data",  128'(out_data),  128'(pat(50)));

    // async reset mid-operation with two entries held
    drive(0, 1, pat(51), 0);
    mdl_edge();
    drive(0, 0, '0, 0);
    chk("pre.occupancy", 128'(occupancy), 128'(2));
    #2 reset = 1'b1;
    #1;
    chk("arst.occupancy", 128'(occupancy), 128'(0));
    chk("arst.out_valid", 128'(out_valid), 128'(0));
    chk("arst.out_data",  128'(out_data),  128'(0));
    chk("arst.stall_cnt", 128'(stall_cnt), 128'(0));
    q.delete(); stall_m = 0; flush_m = 0;
    @(negedge stg_clk);
    reset = 1'b0;

    // randomized traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom_range(7) == 0), ($urandom_range(3) != 0), r[DATA_W-1:0], ($urandom_range(2) != 0));
      chk_model($sformatf("rnd%0d", i));
      mdl_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
